// File: rtl/aes_round_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// aes_ctrl_pkg
// Shared types and constants for the iterative AES round sequencer.
//   state_t   : sequencer FSM states
//   key_len_t : host key-length encoding (00=128, 01=192, 10=256, 11=reserved)
//   nr_of()   : number of rounds Nr for a key length
// -----------------------------------------------------------------------------
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        KL_128  = 2'b00,
        KL_192  = 2'b01,
        KL_256  = 2'b10,
        KL_RSVD = 2'b11
    } key_len_t;

    localparam int         NR_MAX     = 14;
    localparam logic [1:0] KL_ILLEGAL = 2'b11;

    // The reserved encoding never reaches this function through an accepted
    // start; it maps to NR_MAX so the result is always a legal round count.
    function automatic int unsigned nr_of(input key_len_t kl);
        case (kl)
            KL_128:  return 10;
            KL_192:  return 12;
            default: return 14;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer_if
// Host-side handshake bundle of the AES round sequencer.
//   start_valid / start_ready : block start handshake (key_len sampled at accept)
//   key_len                   : key length code for the next block
//   abort                     : synchronous abort request
//   out_valid / out_ready     : result handshake
//   err                       : one-cycle pulse after an illegal key_len start
// Modports: master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface aes_round_sequencer_if;

    logic       start_valid;
    logic       start_ready;
    logic [1:0] key_len;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    modport master (
        output start_valid, key_len, abort, out_ready,
        input  start_ready, out_valid, err
    );

    modport slave (
        input  start_valid, key_len, abort, out_ready,
        output start_ready, out_valid, err
    );

endinterface

// File: rtl/aes_round_sequencer_counter.sv
// -----------------------------------------------------------------------------
// aes_round_counter
// Intra-round cycle counter plus round index counter.
// Ports:
//   clk, reset_n    : clock, async active-low reset
//   clear           : return both counters to zero (highest priority)
//   load            : start of round 1 (round_idx <= 1, cycle counter <= 0)
//   advance         : count cycles inside a round window
//   nr              : number of rounds of the current block
//   round_idx       : current round number, saturates at nr
//   round_last_cyc  : cycle counter is in the last cycle of the round window
//   is_final        : round_idx has reached nr
// -----------------------------------------------------------------------------
module aes_round_counter #(
    parameter int CYC_PER_ROUND = 1,
    parameter int ROUND_W       = 4,
    parameter int CYC_W         = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load,
    input  logic               advance,
    input  logic [ROUND_W-1:0] nr,
    output logic [ROUND_W-1:0] round_idx,
    output logic               round_last_cyc,
    output logic               is_final
);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_PER_ROUND - 1);

    logic [CYC_W-1:0] cyc_cnt;

    assign round_last_cyc = (cyc_cnt == CYC_LAST);
    assign is_final       = (round_idx == nr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt   <= '0;
            round_idx <= '0;
        end else if (clear) begin
            cyc_cnt   <= '0;
            round_idx <= '0;
        end else if (load) begin
            cyc_cnt   <= '0;
            round_idx <= ROUND_W'(1);
        end else if (advance) begin
            if (round_last_cyc) begin
                cyc_cnt <= '0;
                // Hold at Nr: the final round's closing edge must not wrap.
                if (!is_final) begin
                    round_idx <= round_idx + ROUND_W'(1);
                end
            end else begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
// Control FSM for the iterative AES datapath (AES-128/192/256, Nr=10/12/14).
// Sequences plaintext load, Nr round updates and ciphertext capture, with
// CYC_PER_ROUND clock cycles per round; strobes fire in the last cycle of
// each round window.
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   bus (slave)   : start/result handshakes, key_len, abort, err
//   aes_in_en     : load plaintext + initial AddRoundKey (round 0)
//   round_en      : datapath round update strobe
//   key_exp_en    : key expander advance strobe
//   final_round   : current round is Nr (no MixColumns)
//   aes_out_en    : capture ciphertext
//   round_idx     : current round number 0..Nr
//   busy          : sequencer not idle
// -----------------------------------------------------------------------------
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int CYC_PER_ROUND = 1,
    parameter int ROUND_W       = 4,
    parameter int CYC_W         = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    aes_round_sequencer_if.slave bus,
    output logic                aes_in_en,
    output logic                round_en,
    output logic                key_exp_en,
    output logic                final_round,
    output logic                aes_out_en,
    output logic [ROUND_W-1:0]  round_idx,
    output logic                busy
);

    state_t             state;
    state_t             state_nxt;
    logic [ROUND_W-1:0] nr_q;
    logic               err_q;
    logic               accept;
    logic               key_bad;
    logic               round_last_cyc;
    logic               is_final;
    logic               last_mid_round;
    logic               cnt_clear;
    logic               cnt_load;
    logic               cnt_adv;
    logic               out_valid_c;

    // abort in IDLE suppresses the accept (and therefore any err pulse).
    assign accept  = bus.start_valid && (state == IDLE) && !bus.abort;
    assign key_bad = (bus.key_len == KL_ILLEGAL);

    // Round Nr-1 closing: the counter steps round_idx to Nr on this same edge.
    assign last_mid_round = round_last_cyc && (round_idx == nr_q - ROUND_W'(1));

    assign cnt_clear = (state_nxt == IDLE);
    assign cnt_load  = (state == LOAD);
    assign cnt_adv   = (state == ROUND) || (state == FINAL);

    aes_round_counter #(
        .CYC_PER_ROUND (CYC_PER_ROUND),
        .ROUND_W       (ROUND_W),
        .CYC_W         (CYC_W)
    ) u_cnt (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (cnt_clear),
        .load           (cnt_load),
        .advance        (cnt_adv),
        .nr             (nr_q),
        .round_idx      (round_idx),
        .round_last_cyc (round_last_cyc),
        .is_final       (is_final)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Nr is latched only on a legal accept, so later key_len changes are inert.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nr_q  <= ROUND_W'(NR_MAX);
            err_q <= 1'b0;
        end else begin
            err_q <= accept && key_bad;
            if (accept && !key_bad) begin
                nr_q <= ROUND_W'(nr_of(key_len_t'(bus.key_len)));
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !key_bad) state_nxt = LOAD;
            LOAD:    state_nxt = ROUND;
            ROUND:   if (last_mid_round) state_nxt = FINAL;
            FINAL:   if (round_last_cyc) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        aes_in_en   = 1'b0;
        round_en    = 1'b0;
        key_exp_en  = 1'b0;
        final_round = 1'b0;
        aes_out_en  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            LOAD: begin
                aes_in_en  = 1'b1;
                key_exp_en = 1'b1;
            end
            ROUND: begin
                round_en   = round_last_cyc;
                key_exp_en = round_last_cyc;
            end
            FINAL: begin
                final_round = is_final;
                round_en    = round_last_cyc;
                aes_out_en  = round_last_cyc;
            end
            DONE:    out_valid_c = 1'b1;
            default: ;
        endcase
        // An aborted cycle must not disturb the datapath.
        if (bus.abort) begin
            aes_in_en  = 1'b0;
            round_en   = 1'b0;
            key_exp_en = 1'b0;
            aes_out_en = 1'b0;
        end
    end

    assign busy            = (state != IDLE);
    assign bus.start_ready = (state == IDLE);
    assign bus.out_valid   = out_valid_c;
    assign bus.err         = err_q;

endmodule
